// File: rtl/alu_pkg.sv
// alu_pkg: funct codes and one-hot op encoding
// shared by the ALU pipeline and its compute core.
package alu_pkg;

    localparam int FUNCT_ADD = 32;
    localparam int FUNCT_SUB = 34;
    localparam int FUNCT_AND = 36;
    localparam int FUNCT_OR  = 37;
    localparam int FUNCT_NOR = 39;
    localparam int FUNCT_SLT = 42;

    typedef enum logic [6:0] {
        OP_AND = 7'b0000001,
        OP_OR  = 7'b0000010,
        OP_ADD = 7'b0000100,
        OP_SUB = 7'b0001000,
        OP_SLT = 7'b0010000,
        OP_NOR = 7'b0100000,
        OP_ILL = 7'b1000000
    } alu_op_t;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational ALU datapath,
// (a, b, op) -> result plus zero/overflow/illegal flags.
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt;

    assign sum  = a + b;
    assign diff = a - b;
    // Direct signed compare stays exact when a - b overflows.
    assign lt   = $signed(a) < $signed(b);
    assign zero = (result == '0);

    // Select the result for the decoded op and raise its flags.
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOR: result = ~(a | b);
            OP_ADD: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake.
// Optional ALU_PIPE_NOR_EN enables funct 39 as NOR.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [FUNCT_W-1:0] in_funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_ovf,
    output logic               out_illegal
);

    logic [31:0]      funct;
    alu_op_t          dec_op;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_t          s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_ovf;
    logic             s2_illegal;

    logic [WIDTH-1:0] c_result;
    logic             c_zero;
    logic             c_ovf;
    logic             c_illegal;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;

    assign funct    = 32'(in_funct);
    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    // Decode funct into a one-hot op ahead of stage 1.
    always_comb begin
        dec_op = OP_ILL;
        case (funct)
            FUNCT_AND: dec_op = OP_AND;
            FUNCT_OR:  dec_op = OP_OR;
            FUNCT_ADD: dec_op = OP_ADD;
            FUNCT_SUB: dec_op = OP_SUB;
            FUNCT_SLT: dec_op = OP_SLT;
`ifdef ALU_PIPE_NOR_EN
            FUNCT_NOR: dec_op = OP_NOR;
`else
            FUNCT_NOR: dec_op = OP_ILL;
`endif
            default:   dec_op = OP_ILL;
        endcase
    end

    // Stage 1: hold operands and op; refill on the same edge it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ILL;
        end else begin
            s1_valid <= accept || (s1_valid && !s1_adv);
            if (accept) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= dec_op;
            end
        end
    end

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .op      (s1_op),
        .result  (c_result),
        .zero    (c_zero),
        .ovf     (c_ovf),
        .illegal (c_illegal)
    );

    // Stage 2: capture computed result; hold while consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            s2_valid <= s1_adv || (s2_valid && !out_ready);
            if (s1_adv) begin
                s2_result  <= c_result;
                s2_zero    <= c_zero;
                s2_ovf     <= c_ovf;
                s2_illegal <= c_illegal;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_zero    = s2_zero;
    assign out_ovf     = s2_ovf;
    assign out_illegal = s2_illegal;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU.
- Successor to the 1-bit funct-decoded result-select slice. It decodes the R-type funct field and computes AND/OR/ADD/SUB/SLT over WIDTH bits.
- Result and flags are registered behind a valid/ready handshake with full-throughput backpressure.
- Sits between the register-file read stage and writeback in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (min 2).
- FUNCT_W, 6, width of the funct select field.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/funct valid
- in_ready  output  1  block can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_funct  input  FUNCT_W  operation select
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  result
- out_zero  output  1  result == 0
- out_ovf  output  1  signed overflow (ADD/SUB only)
- out_illegal  output  1  funct not recognised

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - s1_valid = 0 and s2_valid = 0; out_valid = 0.
  - out_result, out_zero, out_ovf and out_illegal = 0.
  - in_ready is 1 once reset is released.
- Funct encoding (decimal):
  - AND 36: a & b
  - OR 37: a | b
  - ADD 32: a + b, mod 2^WIDTH
  - SUB 34: a - b, mod 2^WIDTH
  - SLT 42: result = 1 if signed(a) < signed(b), else 0, zero-extended. The comparison is exact even when a - b overflows; do not derive it from the SUB sign bit alone.
- Any other funct (including 33 ADDU and 35 SUBU):
  - result 0, out_illegal = 1.
  - out_zero = 1; out_ovf = 0.
- Overflow:
  - ADD: a[MSB] == b[MSB] and result[MSB] != a[MSB].
  - SUB: a[MSB] != b[MSB] and result[MSB] != a[MSB].
  - out_ovf = 0 for all other ops.
- Stage 1 (S1):
  - Captures in_a, in_b and the decoded op on in_valid & in_ready.
  - Sets s1_valid.
- Stage 2 (S2):
  - Captures the computed result and flags from S1 when S1 advances.
  - out_* are driven directly from S2 registers.
- Handshake rules:
  - S2 advances/empties when out_valid & out_ready.
  - s2_free = !s2_valid | out_ready.
  - S1 advances when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free (combinational; no dependency on in_valid).
- Latency and throughput:
  - Latency is exactly 2 cycles from the accepting edge to out_valid, with no stall.
  - Throughput is 1 result/cycle.
- Backpressure:
  - When out_ready = 0 and both stages are full, in_ready = 0.
  - out_result and out_* flags are held stable while out_valid & !out_ready.
- Simultaneous events:
  - A push into S1 on the same edge that S1 moves to S2 is legal, with no bubble.
  - A stage emptied and refilled on the same edge keeps valid = 1.
- Reset mid-operation: both stages are flushed immediately (async); in-flight results are discarded.
- Ordering: results are in-order and none are dropped or duplicated.

Optional Feature:
- Macro: ALU_PIPE_NOR_EN.
- Defined: funct 39 = NOR, result ~(a | b); out_ovf = 0 and out_illegal = 0.
- Undefined: funct 39 is illegal (result 0, out_illegal = 1).

Decomposition:
- Package alu_pkg holds:
  - FUNCT_AND = 36, FUNCT_OR = 37, FUNCT_ADD = 32, FUNCT_SUB = 34, FUNCT_SLT = 42, FUNCT_NOR = 39.
  - A one-hot op enum alu_op_t (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_ILL).
- One sub-module: alu_pipe_core. It is purely combinational: (a, b, alu_op_t) -> result, zero, ovf, illegal. It is instantiated between S1 and S2.
- The decode funct -> alu_op_t happens before S1 capture, so S1 stores the op, not the funct.

Test Plan:
- Reset, then ADD with a = 5, b = 7, out_ready = 1:
  - out_valid rises 2 cycles after accept.
  - out_result = 12, out_zero = 0, out_ovf = 0.
- SUB with a = 3, b = 5 -> out_result = 0xFFFFFFFE, out_ovf = 0. SUB with a = 0x80000000, b = 1 -> out_result = 0x7FFFFFFF, out_ovf = 1.
- SLT cases:
  - a = 0xFFFFFFFF, b = 1 -> 1.
  - a = 0x7FFFFFFF, b = 0x80000000 -> 0, despite SUB overflow.
  - AND with a = 0xF0F0, b = 0x0FF0 -> 0x00F0. OR with the same operands -> 0xFFF0.
- Stream 4 back-to-back ops with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - out_result is stable while stalled.
  - All 4 results arrive in order, with no loss or duplication.
- Illegal op: funct = 63 -> out_result = 0, out_illegal = 1, out_zero = 1. Funct = 39 gives NOR (a = 0, b = 0 -> 0xFFFFFFFF) only with ALU_PIPE_NOR_EN defined; otherwise it is illegal.
- Reset mid-stream: assert rst asynchronously (between edges) with both stages full:
  - out_valid = 0 immediately.
  - After release, no stale result appears.
  - The next accepted ADD of 1 + 1 yields 2.
